// File: rtl/ranger_pkg.sv
// ranger_pkg: shared types and default timing for the echo_ranger ultrasonic front end.
// Holds the FSM state enum, the cycle-counter width and 100 MHz default timing constants.
// No ports; imported by echo_ranger.
package ranger_pkg;

  localparam int CYC_W         = 22;
  localparam int CYCLES_PER_CM = 5800;

  localparam int DEF_PERIOD_CYCLES = 6500000;  // 65 ms
  localparam int DEF_TRIG_CYCLES   = 1000;     // 10 us
  localparam int DEF_ECHO_TIMEOUT  = 3800000;  // 38 ms
  localparam int DEF_THRESH_CYCLES = 30 * CYCLES_PER_CM;
  localparam int DEF_HYST_CYCLES   = 5 * CYCLES_PER_CM;
  localparam int DEF_CONFIRM       = 3;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    HOLD
  } ranger_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
// Ports: clk (destination clock), d (async input), q (synchronized output, 2-cycle lag).
// The data path carries no reset so both flops can be placed as a plain synchronizer pair.
module sync_2ff (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    meta_q <= d;
    sync_q <= meta_q;
  end

  assign q = sync_q;

endmodule

// File: rtl/echo_ranger.sv
// echo_ranger: HC-SR04-class ranging front end; fires a periodic trigger, times the echo,
// and raises `detected` after CONFIRM consecutive in-range echoes.
// Ports: clk, reset (sync, active-high), echo (async pin) -> trig, detected, echo_cycles,
// valid, timeout. Optional hysteresis band on the miss decision: define ECHO_RANGER_HYST_EN.
module echo_ranger
  import ranger_pkg::*;
#(
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
  parameter int ECHO_TIMEOUT  = DEF_ECHO_TIMEOUT,
  parameter int THRESH_CYCLES = DEF_THRESH_CYCLES,
  parameter int CONFIRM       = DEF_CONFIRM,
  parameter int HYST_CYCLES   = DEF_HYST_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             echo,
  output logic             trig,
  output logic             detected,
  output logic [CYC_W-1:0] echo_cycles,
  output logic             valid,
  output logic             timeout
);

  localparam int PW  = $clog2(PERIOD_CYCLES);
  localparam int HCW = $clog2(CONFIRM + 1);

  localparam logic [PW-1:0]    PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [PW-1:0]    TRIG_END    = PW'(TRIG_CYCLES);
  localparam logic [PW-1:0]    TRIG_LAST   = PW'(TRIG_CYCLES - 1);
  localparam logic [CYC_W-1:0] TMO_LAST    = CYC_W'(ECHO_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] TMO_VAL     = CYC_W'(ECHO_TIMEOUT);
  localparam logic [CYC_W-1:0] THRESH      = CYC_W'(THRESH_CYCLES);
  localparam logic [HCW-1:0]   HIT_MAX     = HCW'(CONFIRM);
`ifdef ECHO_RANGER_HYST_EN
  localparam logic [CYC_W-1:0] MISS_LIMIT  = CYC_W'(THRESH_CYCLES + HYST_CYCLES);
`endif

  // Parameter sanity: a full trigger + timeout must fit inside one period.
  if (PERIOD_CYCLES <= TRIG_CYCLES + ECHO_TIMEOUT + 4) begin : g_bad_period
    $error("echo_ranger: PERIOD_CYCLES too small for TRIG_CYCLES + ECHO_TIMEOUT");
  end
  if (CONFIRM < 1) begin : g_bad_confirm
    $error("echo_ranger: CONFIRM must be at least 1");
  end
  if (THRESH_CYCLES + HYST_CYCLES >= (1 << CYC_W)) begin : g_bad_thresh
    $error("echo_ranger: threshold plus hysteresis exceeds echo_cycles range");
  end

  logic echo_s;

  sync_2ff u_echo_sync (
    .clk (clk),
    .d   (echo),
    .q   (echo_s)
  );

  ranger_state_t    state_q, state_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [CYC_W-1:0] tcnt_q, tcnt_d;
  logic [CYC_W-1:0] ecnt_q, ecnt_d;
  logic [CYC_W-1:0] echo_cycles_q, echo_cycles_d;
  logic [HCW-1:0]   hit_cnt_q, hit_cnt_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             trig_q, trig_d;
  logic             detected_q, detected_d;

  logic pcnt_wrap;
  logic tmo_hit;
  logic is_hit;
  logic is_miss;

  // IDLE holds pcnt at 0 so the first period starts aligned with TRIG entry.
  assign pcnt_wrap = (state_q != IDLE) && (pcnt_q == PERIOD_LAST);
  assign tmo_hit   = ((state_q == WAIT_ECHO) || (state_q == MEASURE)) && (tcnt_q == TMO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pcnt_q        <= '0;
      tcnt_q        <= '0;
      ecnt_q        <= '0;
      echo_cycles_q <= '0;
      hit_cnt_q     <= '0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
      trig_q        <= 1'b0;
      detected_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      tcnt_q        <= tcnt_d;
      ecnt_q        <= ecnt_d;
      echo_cycles_q <= echo_cycles_d;
      hit_cnt_q     <= hit_cnt_d;
      valid_q       <= valid_d;
      timeout_q     <= timeout_d;
      trig_q        <= trig_d;
      detected_q    <= detected_d;
    end
  end

  // Next-state logic; a period wrap outside HOLD aborts whatever is in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = TRIG;
      TRIG:      if (pcnt_q == TRIG_LAST) state_d = WAIT_ECHO;
      WAIT_ECHO: begin
        if (tmo_hit)     state_d = HOLD;
        else if (echo_s) state_d = MEASURE;
      end
      MEASURE:   if (tmo_hit || !echo_s) state_d = HOLD;
      HOLD:      state_d = HOLD;
      default:   state_d = IDLE;
    endcase
    if (pcnt_wrap) state_d = TRIG;
  end

  // Counters, registered outputs and hit classification.
  always_comb begin
    pcnt_d        = (state_q == IDLE || pcnt_wrap) ? '0 : pcnt_q + PW'(1);
    tcnt_d        = tcnt_q;
    ecnt_d        = ecnt_q;
    echo_cycles_d = echo_cycles_q;
    valid_d       = 1'b0;
    timeout_d     = 1'b0;
    trig_d        = (state_q == TRIG) && (pcnt_q < TRIG_END);

    case (state_q)
      TRIG: begin
        tcnt_d = '0;
        ecnt_d = '0;
      end
      WAIT_ECHO: begin
        tcnt_d = tcnt_q + CYC_W'(1);
        // This cycle's echo_s=1 is the first counted sample.
        if (echo_s) ecnt_d = CYC_W'(1);
      end
      MEASURE: begin
        if (echo_s) begin
          tcnt_d = tcnt_q + CYC_W'(1);
          ecnt_d = ecnt_q + CYC_W'(1);
        end
      end
      default: ;
    endcase

    // Timeout takes priority over a simultaneous echo fall; a wrap suppresses both.
    if (!pcnt_wrap) begin
      if (tmo_hit) begin
        valid_d       = 1'b1;
        timeout_d     = 1'b1;
        echo_cycles_d = TMO_VAL;
      end else if (state_q == MEASURE && !echo_s) begin
        valid_d       = 1'b1;
        echo_cycles_d = ecnt_q;
      end
    end

    is_hit = !timeout_d && (echo_cycles_d < THRESH);
`ifdef ECHO_RANGER_HYST_EN
    // Echoes inside the hysteresis band are neither hit nor miss.
    is_miss = timeout_d || (echo_cycles_d >= MISS_LIMIT);
`else
    is_miss = !is_hit;
`endif

    hit_cnt_d = hit_cnt_q;
    if (valid_d) begin
      if (is_hit) begin
        if (hit_cnt_q != HIT_MAX) hit_cnt_d = hit_cnt_q + HCW'(1);
      end else if (is_miss) begin
        hit_cnt_d = '0;
      end
    end
    detected_d = (hit_cnt_d == HIT_MAX);
  end

  assign trig        = trig_q;
  assign detected    = detected_q;
  assign echo_cycles = echo_cycles_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_echo_ranger.sv
// tb_echo_ranger: directed self-checking bench for echo_ranger with small timing parameters.
// Ports: none; drives clk/reset/echo and checks trig, detected, echo_cycles, valid, timeout.
// Expectations are hand-derived cycle positions relative to reset release.
module tb_echo_ranger;

  localparam int PERIOD = 2000;
  localparam int TRIGW  = 10;
  localparam int TMO    = 1000;

  logic        clk;
  logic        reset;
  logic        echo;
  logic        trig;
  logic        detected;
  logic [21:0] echo_cycles;
  logic        valid;
  logic        timeout;

  int cyc       = 0;
  int checks    = 0;
  int errors    = 0;
  int valid_cnt = 0;
  int t0;
  int r2;
  int hi;
  logic exp_hyst;

  echo_ranger #(
    .PERIOD_CYCLES (PERIOD),
    .TRIG_CYCLES   (TRIGW),
    .ECHO_TIMEOUT  (TMO),
    .THRESH_CYCLES (300),
    .CONFIRM       (3),
    .HYST_CYCLES   (50)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .echo        (echo),
    .trig        (trig),
    .detected    (detected),
    .echo_cycles (echo_cycles),
    .valid       (valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid === 1'b1) valid_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
    chk("wait_align", cyc, target);
  endtask

  // Raise echo after edge `start`, hold `width` cycles; valid is due on the 3rd edge after the fall.
  task automatic echo_pulse(input string tag, input int start, input int width, input logic exp_det);
    wait_until(start);
    echo = 1'b1;
    repeat (width) tick();
    echo = 1'b0;
    tick();
    tick();
    chk({tag, "_pre_valid"}, valid, 0);
    tick();
    chk({tag, "_valid"}, valid, 1);
    chk({tag, "_cycles"}, echo_cycles, width);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_detected"}, detected, exp_det);
    tick();
    chk({tag, "_valid_drop"}, valid, 0);
  endtask

  initial begin
`ifdef ECHO_RANGER_HYST_EN
    exp_hyst = 1'b1;
`else
    exp_hyst = 1'b0;
`endif
    reset = 1'b1;
    echo  = 1'b0;
    repeat (3) tick();
    chk("rst_trig", trig, 0);
    chk("rst_detected", detected, 0);
    chk("rst_echo_cycles", echo_cycles, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_hit_cnt", dut.hit_cnt_q, 0);

    // Release: TRIG entered on the next edge (t0), trig visible one edge later.
    reset = 1'b0;
    t0 = cyc + 1;
    tick();
    chk("trig_before", trig, 0);
    tick();
    chk("trig_rise", trig, 1);
    hi = 1;
    repeat (TRIGW - 1) begin
      tick();
      if (trig === 1'b1) hi++;
    end
    chk("trig_width", hi, TRIGW);
    tick();
    chk("trig_fall", trig, 0);
    chk("quiet_detected", detected, 0);

    // Period 0: no echo -> timeout at WAIT_ECHO entry + 1000.
    wait_until(t0 + TRIGW + TMO - 1);
    chk("tmo_pre_valid", valid, 0);
    tick();
    chk("tmo_valid", valid, 1);
    chk("tmo_timeout", timeout, 1);
    chk("tmo_cycles", echo_cycles, TMO);
    chk("tmo_detected", detected, 0);
    tick();
    chk("tmo_valid_drop", valid, 0);
    chk("tmo_timeout_drop", timeout, 0);

    // Trigger repeats one period later.
    wait_until(t0 + PERIOD);
    chk("trig2_before", trig, 0);
    tick();
    chk("trig2_rise", trig, 1);

    // Three in-range echoes confirm detection on the third.
    echo_pulse("hit1", t0 + 1 * PERIOD + 50, 200, 1'b0);
    echo_pulse("hit2", t0 + 2 * PERIOD + 50, 200, 1'b0);
    echo_pulse("hit3", t0 + 3 * PERIOD + 50, 200, 1'b1);
    chk("hit3_hit_cnt", dut.hit_cnt_q, 3);

    // Far echo: miss clears detection.
    echo_pulse("far", t0 + 4 * PERIOD + 50, 500, 1'b0);
    chk("far_hit_cnt", dut.hit_cnt_q, 0);

    // Re-confirm, then an echo inside the hysteresis band.
    echo_pulse("rehit1", t0 + 5 * PERIOD + 50, 200, 1'b0);
    echo_pulse("rehit2", t0 + 6 * PERIOD + 50, 200, 1'b0);
    echo_pulse("rehit3", t0 + 7 * PERIOD + 50, 200, 1'b1);
    echo_pulse("band", t0 + 8 * PERIOD + 50, 320, exp_hyst);

    // Reset in the middle of a measurement.
    wait_until(t0 + 9 * PERIOD + 50);
    echo = 1'b1;
    wait_until(t0 + 9 * PERIOD + 150);
    chk("mid_state_measure", dut.state_q, 3);
    reset = 1'b1;
    tick();
    chk("mrst_trig", trig, 0);
    chk("mrst_detected", detected, 0);
    chk("mrst_echo_cycles", echo_cycles, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_timeout", timeout, 0);
    chk("mrst_hit_cnt", dut.hit_cnt_q, 0);
    echo = 1'b0;
    tick();
    reset = 1'b0;
    r2 = cyc;
    tick();
    chk("mrst_trig_before", trig, 0);
    tick();
    chk("mrst_trig_rise", trig, 1);
    wait_until(r2 + 300);
    chk("mrst_valid_count", valid_cnt, 9);
    chk("mrst_detected_late", detected, 0);
    chk("mrst_cycles_late", echo_cycles, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/echo_ranger.md
# echo_ranger

Ultrasonic ranging front end that drives an HC-SR04-class sensor and produces the `detected` flag consumed by the right-side trigger-window stage. It fires a periodic trigger pulse, times the returned echo in clock cycles, and compares the result against a distance threshold. It asserts `detected` only after a run of consecutive in-range echoes.

## Interface
Parameters:
- `PERIOD_CYCLES`, 6500000: measurement cycle length, 65 ms at 100 MHz.
- `TRIG_CYCLES`, 1000: trigger pulse width, 10 µs.
- `ECHO_TIMEOUT`, 3800000: maximum wait-plus-measure time, 38 ms.
- `THRESH_CYCLES`, 174000: echo width below which an object counts as in range (30 cm at 5800 cycles/cm).
- `CONFIRM`, 3: consecutive hits required to assert `detected`.
- `HYST_CYCLES`, 29000: hysteresis band (5 cm). Used only with `ECHO_RANGER_HYST_EN`.

Ports:
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: synchronous, active-high reset.
- `echo` in 1: raw sensor echo. Asynchronous to `clk`.
- `trig` out 1: sensor trigger.
- `detected` out 1: confirmed object in range.
- `echo_cycles` out 22: last measured echo width in cycles, saturating at `ECHO_TIMEOUT`.
- `valid` out 1: one-cycle strobe; `echo_cycles` updated.
- `timeout` out 1: one-cycle strobe, concurrent with `valid`, when no complete echo arrived.

## Operation
- `echo` passes through a 2-flop synchronizer. All logic uses the synchronized version, `echo_s`.
- Period counter `pcnt` counts free from 0 to `PERIOD_CYCLES-1`, then wraps to 0.
- FSM states are IDLE, TRIG, WAIT_ECHO, MEASURE and HOLD.
- IDLE is entered only from reset. It goes to TRIG on the next cycle, with `pcnt=0`.
- TRIG: `trig=1` while `pcnt < TRIG_CYCLES`. At `pcnt == TRIG_CYCLES-1` the FSM goes to WAIT_ECHO and clears `tcnt`.
- WAIT_ECHO: `tcnt` increments each cycle. `echo_s=1` goes to MEASURE with `ecnt=1`.
- MEASURE: `ecnt` and `tcnt` increment while `echo_s=1`.
  - `echo_s=0` latches `echo_cycles=ecnt` and pulses `valid`, then goes to HOLD.
- Timeout applies in WAIT_ECHO or MEASURE when `tcnt` reaches `ECHO_TIMEOUT-1`.
  - `echo_cycles` is set to `ECHO_TIMEOUT`, and `valid` and `timeout` pulse.
  - The FSM goes to HOLD.
- HOLD: ignores `echo`. A `pcnt` wrap goes to TRIG.
- A `pcnt` wrap in any non-HOLD state aborts the measurement: no `valid`, FSM goes to TRIG, and detection state is unchanged.
- Classification happens on `valid`:
  - hit = `!timeout && echo_cycles < THRESH_CYCLES`; any other result is a miss.
  - A hit increments `hit_cnt`, saturating at `CONFIRM`.
  - A miss clears `hit_cnt`.
- `detected = (hit_cnt == CONFIRM)`, registered. It updates in the same cycle `valid` is high.
- Widths: `ecnt`, `tcnt` and `echo_cycles` are 22-bit unsigned. Comparisons are unsigned.

## Timing
- Reset values: `trig=0`, `detected=0`, `echo_cycles=0`, `valid=0`, `timeout=0`, `hit_cnt=0`, `pcnt=0`, state IDLE.
- First trigger rising edge: 2 cycles after `reset` deasserts.
- `echo_s` lags the `echo` pin by 2 cycles.
- `valid` rises on the 3rd clock edge after the `echo` pin falls.
- `echo_cycles` equals the number of edges at which `echo_s` sampled 1.
- Echo already high when WAIT_ECHO is entered: measurement starts immediately.
- Reset asserted mid-measurement: all state returns to reset values on the next edge, and no `valid` is issued.
- Elaboration asserts `PERIOD_CYCLES > TRIG_CYCLES + ECHO_TIMEOUT + 4` and `CONFIRM >= 1`.

## Configuration
- `ECHO_RANGER_HYST_EN` undefined: miss = not a hit, as defined above.
- `ECHO_RANGER_HYST_EN` defined: miss = `timeout || echo_cycles >= THRESH_CYCLES + HYST_CYCLES`.
  - Echoes within [`THRESH_CYCLES`, `THRESH_CYCLES + HYST_CYCLES`) leave `hit_cnt` and `detected` unchanged.

## Structure
- Package `ranger_pkg` holds:
  - the `ranger_state_t` enum (IDLE, TRIG, WAIT_ECHO, MEASURE, HOLD);
  - a `CYC_W = 22` localparam;
  - default timing constants, including `CYCLES_PER_CM = 5800`.
- Sub-module `sync_2ff` (1-bit synchronizer, no reset on its data path) is instantiated once for `echo`.

## Test plan
Use `PERIOD_CYCLES=2000`, `TRIG_CYCLES=10`, `ECHO_TIMEOUT=1000`, `THRESH_CYCLES=300`, `HYST_CYCLES=50`, `CONFIRM=3`.
- Reset release: `trig` high for exactly 10 cycles starting 2 cycles after release, repeating every 2000 cycles. All other outputs stay 0.
- Echo high 200 cycles, three consecutive periods: `echo_cycles=200` each time. `valid` at pin-fall+3. `detected` rises on the 3rd `valid`.
- Then one echo of 500 cycles: `detected` falls on that `valid` and `hit_cnt` returns to 0.
- No echo: `valid` and `timeout` pulse together at trig end + 1000 with `echo_cycles=1000`. `detected` stays 0.
- Echo of 320 cycles while `detected=1`:
  - with `ECHO_RANGER_HYST_EN`, `detected` stays 1;
  - without it, `detected` falls to 0.
- `reset` pulsed during MEASURE: no `valid` is issued. Outputs return to 0, and the trigger restarts 2 cycles after `reset` deasserts.
